// File: rtl/reg_trace_pkg.sv
// Shared types and frame layout constants for the register trace serializer.
package reg_trace_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [7:0] HDR_DEFAULT      = 8'hA5;
  localparam int         DROP_MAX_DEFAULT = 127;

  localparam int IDX_SEQ  = 1;
  localparam int IDX_STAT = 2;
  localparam int IDX_PC   = 3;
  localparam int IDX_REG  = 7;

  function automatic int flen(input int nreg);
    return IDX_REG + 4 * nreg;
  endfunction

endpackage

// File: rtl/reg_trace_byte_sel.sv
// Combinational mux picking the frame byte at a given index out of the snapshot.
module reg_trace_byte_sel
  import reg_trace_pkg::*;
#(
  parameter int         NREG = 18,
  parameter logic [7:0] HDR  = HDR_DEFAULT,
  parameter int         IW   = 7
) (
  input  logic [IW-1:0]      idx_i,
  input  logic [7:0]         seq_i,
  input  logic [7:0]         stat_i,
  input  logic [31:0]        pc_i,
  input  logic [NREG*32-1:0] regs_i,
  output logic [7:0]         byte_o
);

  localparam int FL = flen(NREG);

  logic [7:0] frame_b [FL];

  assign frame_b[0]        = HDR;
  assign frame_b[IDX_SEQ]  = seq_i;
  assign frame_b[IDX_STAT] = stat_i;

  // Multi-byte fields go out MSB first.
  for (genvar b = 0; b < 4; b++) begin : g_pc
    assign frame_b[IDX_PC+b] = pc_i[24-8*b +: 8];
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign frame_b[IDX_REG+4*k+b] = regs_i[32*k+24-8*b +: 8];
    end
  end

  always_comb begin
    byte_o = 8'h00;
    if (int'(idx_i) < FL) byte_o = frame_b[idx_i];
  end

endmodule

// File: rtl/reg_trace_tx.sv
// Commit-triggered trace serializer: snapshots PC and registers, streams a framed
// byte sequence over valid/ready.
//
//   state | meaning
//   IDLE  | no frame in flight, next enabled commit captures
//   SEND  | frame in flight, idx_q selects the byte presented on tx_data
module reg_trace_tx
  import reg_trace_pkg::*;
#(
  parameter int         NREG     = 18,
  parameter logic [7:0] HDR      = HDR_DEFAULT,
  parameter int         DROP_MAX = DROP_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               commit,
  input  logic [31:0]        pc_in,
  input  logic [NREG*32-1:0] regs_in,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [7:0]         seq
);

  localparam int            FL   = flen(NREG);
  localparam int            IW   = $clog2(FL);
  localparam logic [IW-1:0] LAST = IW'(FL - 1);
  localparam logic [6:0]    DMAX = 7'(DROP_MAX);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         seq_q, seq_d;
  logic [6:0]         drop_q, drop_d;
  logic [7:0]         stat_q, stat_d;
  logic [31:0]        pc_q, pc_d;
  logic [NREG*32-1:0] regs_q, regs_d;

  logic       hs, last_hs, capture;
  logic [7:0] sel_byte;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    regs_d  = regs_q;

    hs      = (state_q == SEND) && tx_ready;
    last_hs = hs && (idx_q == LAST);
    capture = en && commit && ((state_q == IDLE) || last_hs);

    case (state_q)
      IDLE: ;
      SEND: begin
        if (last_hs)  state_d = IDLE;
        else if (hs)  idx_d   = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (en && commit && (state_q == SEND) && !last_hs)
      drop_d = (drop_q == DMAX) ? drop_q : drop_q + 7'd1;

    // A capture on the final handshake chains straight into the next frame.
    if (capture) begin
      state_d = SEND;
      idx_d   = '0;
      seq_d   = seq_q + 8'd1;
      stat_d  = {(drop_q != 7'd0), drop_q};
      drop_d  = 7'd0;
      pc_d    = pc_in;
      regs_d  = regs_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= 8'd0;
      drop_q  <= 7'd0;
      stat_q  <= 8'd0;
      pc_q    <= 32'd0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      regs_q  <= regs_d;
    end
  end

  reg_trace_byte_sel #(
    .NREG (NREG),
    .HDR  (HDR),
    .IW   (IW)
  ) u_byte_sel (
    .idx_i  (idx_q),
    .seq_i  (seq_q),
    .stat_i (stat_q),
    .pc_i   (pc_q),
    .regs_i (regs_q),
    .byte_o (sel_byte)
  );

  assign busy     = (state_q == SEND);
  assign tx_valid = busy;
  assign tx_data  = busy ? sel_byte : 8'h00;
  assign seq      = seq_q;

endmodule

// File: tb/tb_reg_trace_tx.sv
// Randomized bench for reg_trace_tx against a queue-based frame model.
module tb_reg_trace_tx;

  localparam int NREG = 18;
  localparam int FLEN = 7 + 4 * NREG;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              commit = 1'b0;
  logic [31:0]       pc_in = 32'd0;
  logic [NREG*32-1:0] regs_in = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic [7:0]        seq;

  reg_trace_tx #(.NREG(NREG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .commit   (commit),
    .pc_in    (pc_in),
    .regs_in  (regs_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .seq      (seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame in flight is a queue of bytes still to be sent.
  logic [7:0] m_q[$];
  bit         m_busy = 0;
  logic [7:0] m_seq = 8'd0;
  int         m_drop = 0;

  initial begin
    bit m_hs, m_last, m_cap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_busy = 0;
        m_seq  = 8'd0;
        m_drop = 0;
      end else begin
        m_hs   = m_busy && tx_ready;
        m_last = m_hs && (m_q.size() == 1);
        m_cap  = en && commit && (!m_busy || m_last);
        if (en && commit && m_busy && !m_cap)
          m_drop = (m_drop < 127) ? m_drop + 1 : 127;
        if (m_hs) void'(m_q.pop_front());
        if (m_cap) begin
          m_seq = m_seq + 8'd1;
          m_q.delete();
          m_q.push_back(8'hA5);
          m_q.push_back(m_seq);
          m_q.push_back({(m_drop != 0), 7'(m_drop)});
          for (int b = 0; b < 4; b++) m_q.push_back(pc_in[31-8*b -: 8]);
          for (int k = 0; k < NREG; k++)
            for (int b = 0; b < 4; b++) m_q.push_back(regs_in[32*k+31-8*b -: 8]);
          m_drop = 0;
          m_busy = 1;
        end else if (m_last) begin
          m_busy = 0;
        end
      end
    end
  end

  logic [7:0] rx[$];

  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_b = (m_busy && m_q.size() > 0) ? m_q[0] : 8'h00;
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("seq", {24'd0, seq}, {24'd0, m_seq});
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_b});
        if (tx_valid && tx_ready) rx.push_back(tx_data);
      end
    end
  end

  // Stimulus: everything is driven 1 time unit after the rising edge.
  int ready_mode = 0;
  int rcnt = 0;
  bit scramble = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    rcnt++;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
      2: tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    if (scramble) begin
      pc_in = $urandom;
      for (int k = 0; k < NREG; k++) regs_in[32*k +: 32] = $urandom;
    end
  endtask

  task automatic do_reset();
    commit = 1'b0;
    en = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic set_basic_data();
    pc_in = 32'h0040_0010;
    for (int k = 0; k < NREG; k++) regs_in[32*k +: 32] = 32'h1000_0000 + k;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      cyc();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] ref1[$];
  logic [31:0] cap_regs[NREG];

  initial begin
    int n;
    tx_ready = 1'b1;
    do_reset();

    // Reset state.
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_seq", {24'd0, seq}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);

    // 1. Basic frame.
    ready_mode = 0;
    set_basic_data();
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t1_len", rx.size(), FLEN);
    if (rx.size() == FLEN) begin
      check("t1_b0", rx[0], 8'hA5);
      check("t1_b1", rx[1], 8'h01);
      check("t1_b2", rx[2], 8'h00);
      check("t1_b3", rx[3], 8'h00);
      check("t1_b4", rx[4], 8'h40);
      check("t1_b5", rx[5], 8'h00);
      check("t1_b6", rx[6], 8'h10);
      check("t1_b7", rx[7], 8'h10);
      check("t1_b10", rx[10], 8'h00);
      check("t1_b14", rx[14], 8'h01);
      check("t1_b75", rx[75], 8'h10);
      check("t1_b78", rx[78], 8'h11);
    end
    ref1 = rx;

    // 2. Backpressure: identical byte stream.
    do_reset();
    ready_mode = 1;
    set_basic_data();
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t2_len", rx.size(), FLEN);
    if (rx.size() == FLEN && ref1.size() == FLEN)
      for (int i = 0; i < FLEN; i++) check("t2_byte", rx[i], ref1[i]);

    // 3. Drops reported in the following frame.
    do_reset();
    ready_mode = 0;
    pulse_commit();
    for (int i = 0; i < 5; i++) cyc();
    for (int i = 0; i < 3; i++) begin
      pulse_commit();
      cyc();
    end
    wait_idle();
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t3_len", rx.size(), FLEN);
    if (rx.size() == FLEN) begin
      check("t3_seq", rx[1], 8'h02);
      check("t3_stat", rx[2], 8'h83);
    end

    // 3b. Drop counter saturates.
    do_reset();
    ready_mode = 3;
    pulse_commit();
    for (int i = 0; i < 200; i++) pulse_commit();
    ready_mode = 0;
    wait_idle();
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t3b_len", rx.size(), FLEN);
    if (rx.size() == FLEN) check("t3b_stat", rx[2], 8'hFF);

    // 4. Back-to-back on the final handshake.
    do_reset();
    ready_mode = 0;
    pulse_commit();
    n = 0;
    while (!(m_busy && m_q.size() == 1) && n < 200) begin
      cyc();
      n++;
    end
    check("t4_reach_last", {31'd0, (m_busy && m_q.size() == 1)}, 32'd1);
    pulse_commit();
    check("t4_valid", {31'd0, tx_valid}, 32'd1);
    check("t4_hdr", {24'd0, tx_data}, 32'hA5);
    cyc();
    check("t4_seq", {24'd0, tx_data}, 32'h02);
    cyc();
    check("t4_stat", {24'd0, tx_data}, 32'h00);
    wait_idle();

    // 5. Asynchronous reset mid-frame.
    do_reset();
    rx.delete();
    pulse_commit();
    n = 0;
    while (rx.size() < 20 && n < 200) begin
      cyc();
      n++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid", {31'd0, tx_valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_seq", {24'd0, seq}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t5_len", rx.size(), FLEN);
    if (rx.size() == FLEN) begin
      check("t5_hdr", rx[0], 8'hA5);
      check("t5_seq1", rx[1], 8'h01);
    end

    // 6. Enable gating and snapshot isolation.
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 10; i++) pulse_commit();
    check("t6_no_frame", {31'd0, busy}, 32'd0);
    en = 1'b1;
    pc_in = 32'hDEAD_BEEF;
    for (int k = 0; k < NREG; k++) begin
      cap_regs[k] = $urandom;
      regs_in[32*k +: 32] = cap_regs[k];
    end
    scramble = 1;
    rx.delete();
    pulse_commit();
    en = 1'b0;
    for (int i = 0; i < 6; i++) pulse_commit();
    en = 1'b1;
    wait_idle();
    check("t6_len", rx.size(), FLEN);
    if (rx.size() == FLEN) begin
      check("t6_seq", rx[1], 8'h01);
      check("t6_pc0", rx[3], 8'hDE);
      check("t6_pc3", rx[6], 8'hEF);
      for (int k = 0; k < NREG; k++)
        check("t6_reg", {rx[7+4*k], rx[8+4*k], rx[9+4*k], rx[10+4*k]}, cap_regs[k]);
    end
    rx.delete();
    pulse_commit();
    wait_idle();
    check("t6_len2", rx.size(), FLEN);
    if (rx.size() == FLEN) check("t6_stat", rx[2], 8'h00);

    // Random traffic against the model.
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      commit = ($urandom_range(0, 7) == 0);
      cyc();
    end
    commit = 1'b0;
    ready_mode = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
